// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: opcode and FSM state encodings.
package jk_ctrl_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_TOGGLE = 2'b11
    } jkc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_DONE   = 2'b11
    } jkc_state_t;

endpackage

// File: rtl/jk_drive_gen.sv
// Combinational J/K drive for a bank of master-slave JK flip-flops.
// Ports: i_en gates all drive; i_op selects LOAD/UP/DOWN/TOGGLE; i_data is the
// load value; i_q is the live bank output; o_j_c/o_k_c are per-bit J/K lines.
module jk_drive_gen
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_en,
    input  jkc_op_t          i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_j_c,
    output logic [WIDTH-1:0] o_k_c
);

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_borrow;

    // Prefix-AND chains: a bit flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            w_carry[i]  = w_carry[i-1]  &  i_q[i-1];
            w_borrow[i] = w_borrow[i-1] & ~i_q[i-1];
        end
    end

    always_comb begin
        o_j_c = '0;
        o_k_c = '0;
        if (i_en) begin
            case (i_op)
                OP_LOAD: begin
                    o_j_c = i_data;
                    o_k_c = ~i_data;
                end
                OP_UP: begin
                    o_j_c = w_carry;
                    o_k_c = w_carry;
                end
                OP_DOWN: begin
                    o_j_c = w_borrow;
                    o_k_c = w_borrow;
                end
                default: begin
                    o_j_c = '1;
                    o_k_c = '1;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a reset-free JK flip-flop bank: LOAD, count UP/DOWN,
// or TOGGLE for cmd_len steps, one step per ISSUE+SETTLE pair.
// Ports: clk/rst_n; cmd_valid/cmd_ready handshake with cmd_op/cmd_data/cmd_len;
// q is the bank slave output; j/k drive the bank masters (combinational in
// ISSUE); busy/done/steps_left report progress.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    jkc_state_t       r_state;
    jkc_state_t       w_state_nxt;
    jkc_op_t          r_op;
    jkc_op_t          w_op_in;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_steps;
    logic [CNT_W-1:0] w_steps_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_op_in = jkc_op_t'(cmd_op);

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_steps <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_steps <= w_steps_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_op   <= w_op_in;
                r_data <= cmd_data;
            end
        end
    end

    // Next-state and step-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_steps_nxt = cmd_len;
                    // A zero-length step command completes without touching the bank.
                    if (w_op_in == OP_LOAD || cmd_len != '0) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                w_steps_nxt = (r_op == OP_LOAD) ? '0 : r_steps - CNT_W'(1);
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_state_nxt = (r_steps != '0) ? ST_ISSUE : ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    jk_drive_gen #(
        .WIDTH (WIDTH)
    ) u_drive (
        .i_en   (r_state == ST_ISSUE),
        .i_op   (r_op),
        .i_data (r_data),
        .i_q    (q),
        .o_j_c  (w_j),
        .o_k_c  (w_k)
    );

    assign j          = w_j;
    assign k          = w_k;
    assign cmd_ready  = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_steps;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl with a behavioural JK bank attached.
module tb_jk_bank_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    jk_bank_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .q          (q),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master-slave JK bank: master samples on posedge, slave follows on negedge.
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] bq;
    initial begin
        bm = 4'b1100;
        bq = 4'b1100;
    end
    always @(posedge clk) bm <= (j & ~bq) | (~k & bq);
    always @(negedge clk) bq <= bm;
    assign q = bq;

    typedef struct {
        bit         ready;
        bit         busy;
        bit         done;
        logic [7:0] steps;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
        bit         qchk;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ce;
    logic [3:0] qm;
    bit         q_known;
    bit         chk_en;
    int         n_cmp;
    int         n_err;

    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, TOG = 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input bit r, input bit b, input bit d, input logic [7:0] s,
                                input logic [3:0] jj, input logic [3:0] kk,
                                input logic [3:0] qq, input bit qc);
        exp_t e;
        e.ready = r; e.busy = b; e.done = d; e.steps = s;
        e.j = jj; e.k = kk; e.q = qq; e.qchk = qc;
        return e;
    endfunction

    // Per-cycle expectations of a command, from its arithmetic meaning.
    task automatic build(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        logic [3:0] nv;
        if (op == LOAD) begin
            exp_q.push_back(mk(0, 1, 0, len, data, ~data, qm, q_known));
            exp_q.push_back(mk(0, 1, 0, 8'd0, 4'd0, 4'd0, qm, q_known));
            qm = data;
            q_known = 1'b1;
            exp_q.push_back(mk(0, 1, 1, 8'd0, 4'd0, 4'd0, qm, 1'b1));
        end else begin
            for (int s = 0; s < int'(len); s++) begin
                case (op)
                    UP:      nv = qm + 4'd1;
                    DOWN:    nv = qm - 4'd1;
                    default: nv = ~qm;
                endcase
                exp_q.push_back(mk(0, 1, 0, len - 8'(s), qm ^ nv, qm ^ nv, qm, q_known));
                exp_q.push_back(mk(0, 1, 0, len - 8'(s) - 8'd1, 4'd0, 4'd0, qm, q_known));
                qm = nv;
            end
            exp_q.push_back(mk(0, 1, 1, 8'd0, 4'd0, 4'd0, qm, q_known));
        end
    endtask

    // Cycle-by-cycle compare against the model queue (idle when empty).
    always begin
        @(posedge clk);
        #1;
        if (chk_en && rst_n) begin
            if (exp_q.size() > 0) ce = exp_q.pop_front();
            else                  ce = mk(1, 0, 0, 8'd0, 4'd0, 4'd0, qm, q_known);
            chk("cmd_ready",  32'(cmd_ready),  32'(ce.ready));
            chk("busy",       32'(busy),       32'(ce.busy));
            chk("done",       32'(done),       32'(ce.done));
            chk("steps_left", 32'(steps_left), 32'(ce.steps));
            chk("j",          32'(j),          32'(ce.j));
            chk("k",          32'(k),          32'(ce.k));
            if (ce.qchk) chk("q", 32'(q), 32'(ce.q));
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!cmd_ready && n < 80);
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        build(op, data, len);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
        wait_ready();
        drive(op, data, len);
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; chk_en = 1'b0; q_known = 1'b0; qm = 4'd0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0; cmd_len = 8'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_steps", 32'(steps_left), 32'd0);
        chk("rst_j",     32'(j),         32'd0);
        chk("rst_k",     32'(k),         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // LOAD 1010 with literal pins on ISSUE drive and DONE timing.
        wait_ready();
        drive(LOAD, 4'b1010, 8'd0);
        @(posedge clk); #2;
        chk("load_issue_j", 32'(j), 32'(4'b1010));
        chk("load_issue_k", 32'(k), 32'(4'b0101));
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("load_settle_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        chk("load_done_T2", 32'(done), 32'd1);
        chk("load_q", 32'(q), 32'(4'b1010));

        // UP with wrap through all-ones.
        send(LOAD, 4'b1101, 8'd7);
        send(UP, 4'b0000, 8'd5);
        wait_ready();
        chk("up_wrap_q", 32'(q), 32'(4'b0010));

        // DOWN with wrap through zero.
        send(LOAD, 4'b0001, 8'd0);
        send(DOWN, 4'b0000, 8'd3);
        wait_ready();
        chk("down_wrap_q", 32'(q), 32'(4'b1110));

        // TOGGLE twice returns to start; zero-length UP leaves the bank alone.
        send(LOAD, 4'b0110, 8'd0);
        send(TOG, 4'b0000, 8'd2);
        wait_ready();
        chk("toggle_q", 32'(q), 32'(4'b0110));
        send(UP, 4'b0000, 8'd0);
        wait_ready();
        chk("up0_q", 32'(q), 32'(4'b0110));

        // Valid held through busy with a different op: taken only after idle.
        wait_ready();
        drive(UP, 4'b0000, 8'd2);
        @(negedge clk); #1;
        cmd_op   = TOG;
        cmd_data = 4'b1111;
        cmd_len  = 8'd1;
        exp_q.push_back(mk(1, 0, 0, 8'd0, 4'd0, 4'd0, qm, q_known));
        build(TOG, 4'b1111, 8'd1);
        wait_ready();
        @(negedge clk); #1;
        cmd_valid = 1'b0;
        wait_ready();
        chk("held_q", 32'(q), 32'(4'b0111));

        // Reset in the middle of an UP run aborts immediately.
        send(LOAD, 4'b0011, 8'd0);
        send(UP, 4'b0000, 8'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        q_known = 1'b0;
        #1;
        chk("abort_j",     32'(j),         32'd0);
        chk("abort_k",     32'(k),         32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_done",  32'(done),      32'd0);
        chk("abort_steps", 32'(steps_left), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(LOAD, 4'b0101, 8'd0);
        wait_ready();
        chk("reload_q", 32'(q), 32'(4'b0101));
        send(UP, 4'b0000, 8'd1);
        wait_ready();
        chk("reload_up_q", 32'(q), 32'(4'b0110));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
